// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared definitions for the multi-cycle integer divider.
//                - DIV_WIDTH          : default operand width
//                - DIV_ZERO_QUOTIENT  : all-ones quotient returned on x/0
//                                       (slice the low WIDTH bits, WIDTH<=64)
//                - div_ctrl_t         : control-strobe bundle driven by the
//                                       divider FSM into the datapath
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

  typedef struct packed {
    logic initialize;     // load operands, start a new division
    logic load_divident;  // subtract step
    logic sh_en;          // shift step
  } div_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/div_step_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_step_unit
//  Description : Combinational compare/subtract of the partial remainder
//                against the divisor for the shift-subtract divider.
//  Ports       : rem   in  WIDTH+1  partial remainder R
//                dvs   in  WIDTH    divisor D
//                dz    in  1        divide-by-zero flag of current operation
//                gt    out 1        R >= D, suppressed when D==0 or dz
//                diff  out WIDTH+1  R - D
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step_unit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] dvs,
  input  logic             dz,
  output logic             gt,
  output logic [WIDTH:0]   diff
);

  logic [WIDTH:0] w_dvs_ext;

  assign w_dvs_ext = {1'b0, dvs};

  // A zero divisor only exists out of reset or on a divide-by-zero; in both
  // cases no subtract may be requested, so the flag is masked for D==0 too.
  assign gt   = !dz && (dvs != '0) && (rem >= w_dvs_ext);
  assign diff = rem - w_dvs_ext;

endmodule
`default_nettype wire

// File: rtl/divider_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : divider_datapath
//  Description : Shift-subtract datapath of the multi-cycle MIPS divider.
//                Holds the operands, partial remainder R, quotient Q and the
//                iteration count, reacts to the FSM strobes and reports the
//                status flags the FSM sequences on.
//  Config      : SIGNED_DIV_EN - adds div_signed input; operands are taken
//                as magnitudes and the results sign-corrected on output.
//  Ports       : CLK                  in  1      clock, rising edge
//                RST                  in  1      async reset, active-low
//                dividend / divisor   in  WIDTH  operands, sampled on initialize
//                initialize           in  1      start new division
//                load_divident        in  1      subtract step
//                sh_en                in  1      shift step
//                div_signed           in  1      (SIGNED_DIV_EN only)
//                divident_gt_divisor  out 1      R >= D
//                done                 out 1      result valid
//                div_by_zero          out 1      sticky x/0 flag
//                quotient             out WIDTH  LO result
//                remainder            out WIDTH  HI result
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             initialize,
  input  logic             load_divident,
  input  logic             sh_en,
`ifdef SIGNED_DIV_EN
  input  logic             div_signed,
`endif
  output logic             divident_gt_divisor,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [CNT_W-1:0] c_iter_cnt  = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] c_dz_quot   = DIV_ZERO_QUOTIENT[WIDTH-1:0];

  div_ctrl_t        w_ctrl;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dz;
  logic             w_gt;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;

  assign w_ctrl = '{initialize: initialize, load_divident: load_divident, sh_en: sh_en};

  // --------------------------------------------------------------------------
  // Operand conditioning: magnitudes in signed mode, raw operands otherwise.
  // --------------------------------------------------------------------------
`ifdef SIGNED_DIV_EN
  logic w_neg_a;
  logic w_neg_b;
  logic r_sq;
  logic r_sr;

  assign w_neg_a = div_signed && dividend[WIDTH-1];
  assign w_neg_b = div_signed && divisor[WIDTH-1];
  assign w_op_a  = w_neg_a ? (WIDTH'(0) - dividend) : dividend;
  assign w_op_b  = w_neg_b ? (WIDTH'(0) - divisor)  : divisor;

  // Result sign flags; cleared on divide-by-zero, whose result is raw.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sq <= 1'b0;
      r_sr <= 1'b0;
    end else if (w_ctrl.initialize) begin
      r_sq <= (divisor != '0) && (w_neg_a ^ w_neg_b);
      r_sr <= (divisor != '0) && w_neg_a;
    end
  end
`else
  assign w_op_a = dividend;
  assign w_op_b = divisor;
`endif

  div_step_unit #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem  (r_rem),
    .dvs  (r_dvs),
    .dz   (r_dz),
    .gt   (w_gt),
    .diff (w_diff)
  );

  // --------------------------------------------------------------------------
  // State registers. Priority: initialize > load_divident > sh_en.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_dz  <= 1'b0;
    end else if (w_ctrl.initialize) begin
      if (divisor == '0) begin
        // Raw dividend goes to HI even in signed mode.
        r_rem <= {1'b0, dividend};
        r_quo <= c_dz_quot;
        r_dvs <= '0;
        r_cnt <= '0;
        r_dz  <= 1'b1;
      end else begin
        r_rem <= '0;
        r_quo <= w_op_a;
        r_dvs <= w_op_b;
        r_cnt <= c_iter_cnt;
        r_dz  <= 1'b0;
      end
    end else if (w_ctrl.load_divident) begin
      // Defensive: a subtract without R >= D (or on x/0) is dropped.
      if (w_gt) begin
        r_rem    <= w_diff;
        r_quo[0] <= 1'b1;
      end
    end else if (w_ctrl.sh_en) begin
      // Once the count is exhausted, shifts are ignored so that the FSM's
      // final OPER-cycle strobe cannot disturb the finished result.
      if (r_cnt != '0) begin
        {r_rem, r_quo} <= {r_rem[WIDTH-1:0], r_quo, 1'b0};
        r_cnt          <= r_cnt - 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Flags and result outputs
  // --------------------------------------------------------------------------
  assign divident_gt_divisor = w_gt;
  assign done                = (r_cnt == '0) && !w_gt;
  assign div_by_zero         = r_dz;

`ifdef SIGNED_DIV_EN
  assign quotient  = r_sq ? (WIDTH'(0) - r_quo) : r_quo;
  assign remainder = r_sr ? (WIDTH'(0) - r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];
`else
  assign quotient  = r_quo;
  assign remainder = r_rem[WIDTH-1:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_divider_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_datapath
//  Description : Self-checking bench for divider_datapath (WIDTH=8). Plays
//                the role of the divider FSM and checks results, flags and
//                OPER-cycle latency against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_datapath;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         initialize = 1'b0;
  logic         load_divident = 1'b0;
  logic         sh_en = 1'b0;
`ifdef SIGNED_DIV_EN
  logic         div_signed = 1'b0;
`endif
  logic         divident_gt_divisor;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int checks   = 0;
  int failures = 0;

  divider_datapath #(
    .WIDTH (W)
  ) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .dividend            (dividend),
    .divisor             (divisor),
    .initialize          (initialize),
    .load_divident       (load_divident),
    .sh_en               (sh_en),
`ifdef SIGNED_DIV_EN
    .div_signed          (div_signed),
`endif
    .divident_gt_divisor (divident_gt_divisor),
    .done                (done),
    .div_by_zero         (div_by_zero),
    .quotient            (quotient),
    .remainder           (remainder)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int popcnt(input logic [W-1:0] v);
    int c = 0;
    for (int i = 0; i < W; i++) c += int'(v[i]);
    return c;
  endfunction

  // Reference model: plain arithmetic on the operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output int lat, output bit dz);
    logic [W-1:0] ma, mb, uq, ur;
    if (b == 0) begin
      q = '1; r = a; lat = 1; dz = 1'b1;
    end else begin
      dz = 1'b0;
      ma = (sgn && a[W-1]) ? W'(0) - a : a;
      mb = (sgn && b[W-1]) ? W'(0) - b : b;
      uq = ma / mb;
      ur = ma % mb;
      q  = (sgn && (a[W-1] ^ b[W-1])) ? W'(0) - uq : uq;
      r  = (sgn && a[W-1]) ? W'(0) - ur : ur;
      lat = W + popcnt(uq) + 1;
    end
  endtask

  // Runs one division as the FSM would. abort_at>0 pulls RST low on that
  // OPER cycle; hold keeps strobing sh_en for that many cycles after done.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                         input int abort_at, input int hold,
                         output logic [W-1:0] oq, output logic [W-1:0] orr,
                         output int olat, output int oloads);
    logic [W-1:0] eq, er;
    int  elat;
    bit  edz;
    int  n;
    bit  fin;
    model(a, b, sgn, eq, er, elat, edz);
    oq = 'x; orr = 'x; olat = -1; oloads = 0;
    @(negedge CLK);
    load_divident = 1'b0;
    sh_en         = 1'b0;
    dividend      = a;
    divisor       = b;
    initialize    = 1'b1;
`ifdef SIGNED_DIV_EN
    div_signed    = sgn;
`endif
    n = 0; fin = 1'b0;
    while (!fin) begin
      @(negedge CLK);
      initialize = 1'b0; load_divident = 1'b0; sh_en = 1'b0;
      n++;
      if (n > elat) begin
        checks++; failures++;
        $display("FAIL timeout: no done by OPER cycle %0d, expected %0d", n, elat);
        fin = 1'b1;
      end else if (n == abort_at) begin
        RST = 1'b0;
        #1;
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_done", done, 1);
        chk("abort_gt", divident_gt_divisor, 0);
        @(negedge CLK);
        RST = 1'b1;
        fin = 1'b1;
      end else begin
        chk("done_timing", done, n == elat);
        if (edz) chk("dz_gt", divident_gt_divisor, 0);
        if (divident_gt_divisor) begin
          load_divident = 1'b1;
          oloads++;
        end else begin
          sh_en = 1'b1;
          if (done) begin
            oq = quotient; orr = remainder; olat = n;
            chk("quotient", quotient, eq);
            chk("remainder", remainder, er);
            chk("div_by_zero", div_by_zero, edz);
            fin = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      sh_en = 1'b1;
      chk("hold_quotient", quotient, eq);
      chk("hold_remainder", remainder, er);
      chk("hold_done", done, 1);
      if (edz) chk("hold_dz_gt", divident_gt_divisor, 0);
    end
  endtask

  logic [W-1:0] q, r, ra, rb;
  int lat, loads;
  bit rs;

  initial begin
    // Reset state
    #2;
    chk("rst_gt", divident_gt_divisor, 0);
    chk("rst_done", done, 1);
    chk("rst_dz", div_by_zero, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    @(negedge CLK);
    RST = 1'b1;

    run_div(8'd100, 8'd7, 1'b0, 0, 0, q, r, lat, loads);
    chk("100/7_q", q, 14);
    chk("100/7_r", r, 2);
    chk("100/7_lat", lat, 12);
    chk("100/7_loads", loads, 3);

    run_div(8'd255, 8'd1, 1'b0, 0, 5, q, r, lat, loads);
    chk("255/1_q", q, 255);
    chk("255/1_r", r, 0);
    chk("255/1_lat", lat, 17);

    run_div(8'd37, 8'd0, 1'b0, 0, 3, q, r, lat, loads);
    chk("37/0_q", q, 8'hFF);
    chk("37/0_r", r, 37);
    chk("37/0_lat", lat, 1);
    chk("37/0_dz", div_by_zero, 1);

    run_div(8'd5, 8'd200, 1'b0, 0, 0, q, r, lat, loads);
    chk("5/200_q", q, 0);
    chk("5/200_r", r, 5);
    chk("5/200_lat", lat, 9);
    chk("5/200_loads", loads, 0);

    run_div(8'd100, 8'd7, 1'b0, 4, 0, q, r, lat, loads);
    run_div(8'd100, 8'd7, 1'b0, 0, 0, q, r, lat, loads);
    chk("post_abort_q", q, 14);
    chk("post_abort_r", r, 2);
    chk("post_abort_lat", lat, 12);

`ifdef SIGNED_DIV_EN
    run_div(8'hF9, 8'd2, 1'b1, 0, 0, q, r, lat, loads);
    chk("s-7/2_q", q, 8'hFD);
    chk("s-7/2_r", r, 8'hFF);
    run_div(8'h80, 8'hFF, 1'b1, 0, 0, q, r, lat, loads);
    chk("s80/FF_q", q, 8'h80);
    chk("s80/FF_r", r, 0);
`endif

    for (int k = 0; k < 60; k++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 8'd0;
        1:       rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
`ifdef SIGNED_DIV_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_div(ra, rb, rs, 0, $urandom_range(0, 2), q, r, lat, loads);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
